// File: rtl/tristate_bus_arbiter.sv
// Two-requester arbiter producing exclusive enables for a shared tri-state net.
// Round-robin on ties, bounded ownership with forced release, and a fixed
// all-low turnaround gap between owners.
module tristate_bus_arbiter #(
  parameter int TURN_CYCLES = 1,
  parameter int HOLD_MAX    = 8
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [1:0] i_req,
  output logic       o_d1_en,
  output logic       o_d2_en,
  output logic       o_busy,
  output logic       o_owner,
  output logic       o_preempt
);

  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int TW = $clog2(TURN_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(HOLD_MAX);
  localparam logic [TW-1:0] TURN_LIMIT = TW'(TURN_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_owner;
  logic          r_last;
  logic [HW-1:0] r_hold;
  logic [TW-1:0] r_turn;
  logic          r_d1_en;
  logic          r_d2_en;
  logic          r_busy;
  logic          r_preempt;

  logic w_grant;
  logic w_winner;

  // Arbitration: a lone requester wins; on a tie the one that did not win last time.
  always_comb begin
    w_grant  = |i_req;
    w_winner = (i_req == 2'b11) ? ~r_last : i_req[1];
  end

  // Control FSM; enables/busy are registered decodes updated on every state change.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_hold    <= '0;
      r_turn    <= '0;
      r_d1_en   <= 1'b0;
      r_d2_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state <= S_OWN;
            r_owner <= w_winner;
            r_last  <= w_winner;
            r_hold  <= HW'(1);
            r_d1_en <= ~w_winner;
            r_d2_en <= w_winner;
            r_busy  <= 1'b1;
          end
        end
        S_OWN: begin
          if (!i_req[r_owner]) begin
            r_state <= S_TURN;
            r_turn  <= TW'(1);
            r_d1_en <= 1'b0;
            r_d2_en <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_hold == HOLD_LIMIT && i_req[~r_owner]) begin
            r_state   <= S_TURN;
            r_turn    <= TW'(1);
            r_d1_en   <= 1'b0;
            r_d2_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_preempt <= 1'b1;
          end else if (r_hold != HOLD_LIMIT) begin
            r_hold <= r_hold + HW'(1);
          end
        end
        S_TURN: begin
          if (r_turn == TURN_LIMIT) begin
            if (w_grant) begin
              r_state <= S_OWN;
              r_owner <= w_winner;
              r_last  <= w_winner;
              r_hold  <= HW'(1);
              r_d1_en <= ~w_winner;
              r_d2_en <= w_winner;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_turn <= r_turn + TW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_d1_en <= 1'b0;
          r_d2_en <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_d1_en   = r_d1_en;
  assign o_d2_en   = r_d2_en;
  assign o_busy    = r_busy;
  assign o_owner   = r_owner;
  assign o_preempt = r_preempt;

endmodule
